j_mac_accum: RTL
================

# j_mac_accum

Sequenced 40-bit multiply-accumulate register for the Jerry DSP datapath. Accepts a stream of signed 32-bit products from the 16x16 multiplier and sign-extends each to 40 bits. Adds or subtracts each into a guarded accumulator over a programmed number of terms. Presents the low 32 bits plus the 8 guard bits to the downstream saturation stage, which narrows the result back to 16 or 32 bits.

## Interface
Parameters:
- ACC_W, 40, accumulator width (32 data bits + 8 guard bits)
- CNT_W, 4, term-counter width; count 0 encodes 16 terms

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  begin a sequence; sampled only in IDLE
- keep  in  1  sampled with start: 1 = accumulate onto the current accumulator, 0 = clear to 0 first
- count  in  4  number of terms; 0 = 16
- prod  in  32  signed product, bit 0 = LSB
- prod_valid  in  1  prod is presented this cycle
- sub  in  1  qualifies prod_valid: 1 = subtract this term
- prod_ready  out  1  term accepted this cycle when prod_valid & prod_ready
- q  out  32  accumulator bits 0..31
- acc_hi  out  8  accumulator bits 32..39; acc_hi bit 0 = accum bit 32
- busy  out  1  sequence in progress
- done  out  1  one-cycle pulse, result final
- ovf  out  1  sticky 40-bit signed overflow

## Operation
- The state machine has three states: IDLE, RUN and DONE.
- IDLE:
  - prod_ready=0, busy=0.
  - If start=1: load the term counter with count (0 → 16).
  - If keep=0, clear the accumulator; if keep=1, leave it unchanged.
  - Clear ovf and go to RUN.
- RUN:
  - busy=1 and prod_ready=1.
  - On each accepted term, the accumulator becomes accum ± sext40(prod), using 40-bit two's complement with wrap.
  - ovf is set if the operands have equal signs (for add) or opposite signs (for sub) and the result sign differs from accum bit 39.
  - Each accepted term decrements the counter.
  - When the final term is accepted, go to DONE.
  - Cycles with prod_valid=0 are stalls: nothing changes.
- DONE:
  - done=1, busy=1, prod_ready=0 for exactly one cycle, then go to IDLE.
- start is ignored outside IDLE.
- prod_valid is ignored outside RUN; no term is accepted there.
- The accumulator holds its value in IDLE, so q/acc_hi stay readable until the next start with keep=0.
- ovf persists through IDLE until the next start.

## Timing
- Reset values: state=IDLE, accumulator=0, counter=0.
- Outputs at reset: q=0, acc_hi=0, busy=0, done=0, ovf=0, prod_ready=0.
- All outputs are registered or decoded from state only; there is no combinational path from prod/prod_valid to any output.
- Start latency: start is sampled at edge N; busy=1 and prod_ready=1 from cycle N+1.
- Term latency: a term accepted at edge M appears on q/acc_hi after edge M.
- Completion: the last term is accepted at edge M; done=1 during cycle M+1; busy=0 from cycle M+2.
- With no stalls, an n-term sequence runs start → done in n+1 cycles.
- Reset asserted mid-sequence aborts immediately and discards the partial result.
- Counter boundary: count=1 → a single term then DONE; count=0 → exactly 16 terms.
- Wrap: the accumulator wraps modulo 2^40. ovf records the wrap; the value is not clamped here, because saturation is downstream.

## Structure
- Shared DSP package:
  - state encoding (IDLE=0, RUN=1, DONE=2)
  - ACC_W, CNT_W
  - the sext32to40 helper
- One natural sub-module, j_acc_addsub: 40-bit add/subtract with overflow output, purely combinational. The top holds the FSM, counter and registers.

## Test plan
- Reset, then start with keep=0, count=3; feed products 0x00000005, 0x00000007, 0x00000002 on consecutive cycles → q=0x0000000E, acc_hi=0x00, done in the 4th cycle after start, ovf=0.
- Start with keep=0, count=2; feed 0x7FFFFFFF twice → q=0xFFFFFFFE, acc_hi=0x00, ovf=0. The downstream 32-bit saturation must see a positive overflow.
- Start with keep=0, count=1; feed 0x00000001 with sub=1 → q=0xFFFFFFFF, acc_hi=0xFF.
- Start with keep=1, count=1 after the previous result; feed 0x00000001 → q=0, acc_hi=0x00.
- Start with keep=0, count=0; feed 16 terms of 0x40000000 with prod_valid deasserted on alternate cycles:
  - stalls hold state;
  - result has acc_hi=0x04, q=0;
  - done arrives exactly one cycle after the 16th accepted term.
- Preload the accumulator to 0x7F_FFFFFFFF via repeated sequences, then add 1 → acc_hi=0x80, q=0, ovf=1; ovf clears on the next start.
- Assert reset during RUN after 2 of 5 terms → all outputs return to 0 immediately; a following start with keep=1 accumulates from 0.
- Assert start during RUN → ignored; the counter and result are unaffected.

Source files
------------

// File: rtl/j_mac_accum_pkg.sv
// rtl/j_mac_accum_pkg.sv - shared DSP package for the Jerry MAC accumulator
// Purpose: state encoding, accumulator/counter widths and the product
//          sign-extension helper used by j_mac_accum and j_acc_addsub.
// Ports:   none (package)
package j_mac_accum_pkg;

  localparam int ACC_W  = 40;
  localparam int CNT_W  = 4;
  localparam int PROD_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic [ACC_W-1:0] sext32to40(input logic [PROD_W-1:0] v);
    return {{(ACC_W-PROD_W){v[PROD_W-1]}}, v};
  endfunction

endpackage

// File: rtl/j_acc_addsub.sv
// rtl/j_acc_addsub.sv - 40-bit add/subtract with signed overflow flag
// Purpose: combinational sum_o = a_i +/- b_i, wrapping modulo 2^ACC_W.
// Ports:   a_i   in  ACC_W  current accumulator
//          b_i   in  ACC_W  sign-extended operand
//          sub_i in  1      1 = a_i - b_i, 0 = a_i + b_i
//          sum_o out ACC_W  wrapped result
//          ovf_o out 1      signed overflow of this operation
module j_acc_addsub
  import j_mac_accum_pkg::*;
(
  input  logic [ACC_W-1:0] a_i,
  input  logic [ACC_W-1:0] b_i,
  input  logic             sub_i,
  output logic [ACC_W-1:0] sum_o,
  output logic             ovf_o
);

  logic b_sign_eff;

  always_comb begin
    sum_o      = sub_i ? (a_i - b_i) : (a_i + b_i);
    // Subtraction adds the negated operand, so its effective sign flips.
    b_sign_eff = sub_i ? ~b_i[ACC_W-1] : b_i[ACC_W-1];
    ovf_o      = (a_i[ACC_W-1] == b_sign_eff) && (sum_o[ACC_W-1] != a_i[ACC_W-1]);
  end

endmodule

// File: rtl/j_mac_accum.sv
// rtl/j_mac_accum.sv - sequenced 40-bit multiply-accumulate register
// Purpose: accumulates a programmed number of signed 32-bit products into a
//          40-bit guarded accumulator (add or subtract per term) and presents
//          the low 32 bits plus 8 guard bits to the saturation stage.
// Ports:   clk        in  1   system clock
//          reset      in  1   asynchronous active-high reset
//          start      in  1   begin a sequence (IDLE only)
//          keep       in  1   1 = accumulate onto current value, 0 = clear first
//          count      in  4   number of terms, 0 = 16
//          prod       in  32  signed product
//          prod_valid in  1   prod presented this cycle
//          sub        in  1   subtract this term
//          prod_ready out 1   term accepted when prod_valid & prod_ready
//          q          out 32  accumulator bits 31..0
//          acc_hi     out 8   accumulator bits 39..32
//          busy       out 1   sequence in progress
//          done       out 1   one-cycle result-final pulse
//          ovf        out 1   sticky 40-bit signed overflow
module j_mac_accum
  import j_mac_accum_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              keep,
  input  logic [CNT_W-1:0]  count,
  input  logic [PROD_W-1:0] prod,
  input  logic              prod_valid,
  input  logic              sub,
  output logic              prod_ready,
  output logic [31:0]       q,
  output logic [ACC_W-33:0] acc_hi,
  output logic              busy,
  output logic              done,
  output logic              ovf
);

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  logic [ACC_W-1:0] sum;
  logic             term_ovf;

  j_acc_addsub u_addsub (
    .a_i   (acc_q),
    .b_i   (sext32to40(prod)),
    .sub_i (sub),
    .sum_o (sum),
    .ovf_o (term_ovf)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          // count=0 loads 0; the first decrement wraps to 15, giving 16 terms.
          cnt_d   = count;
          ovf_d   = 1'b0;
          state_d = ST_RUN;
          if (!keep) acc_d = '0;
        end
      end
      ST_RUN: begin
        if (prod_valid) begin
          acc_d = sum;
          ovf_d = ovf_q | term_ovf;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake and status decode from state only, keeping prod off every output path.
  assign prod_ready = (state_q == ST_RUN);
  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_DONE);
  assign q          = acc_q[31:0];
  assign acc_hi     = acc_q[ACC_W-1:32];
  assign ovf        = ovf_q;

endmodule
